input_mailbox: RTL
==================

Name: input_mailbox

Overview:
- Memory-mapped input stage for the Tron CPU. Sits directly upstream of the dual-port memory and drives its second write port (addr2/dataIn2/we2).
- Synchronises and debounces the board push-buttons, then posts each press event as one word into a fixed mailbox address.
- Waits for the CPU to acknowledge the word by clearing its VALID bit before posting again. Presses arriving in the meantime are accumulated, not lost.

Parameters:
- MAILBOX_ADDR, 16'h8001, memory address of the mailbox word (next to the IO-enable word at 16'h8000).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced level changes; legal range 1..65535.
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed; 0 = active-high.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  4  asynchronous raw push-button inputs.
- io_en  input  1  IO enable, high when the IO-enable word equals 16'h0001; gates posting only.
- dataOut2  input  16  memory port-2 read data; registered-address read of addr2.
- addr2  output  16  memory port-2 address; constant MAILBOX_ADDR.
- dataIn2  output  16  memory port-2 write data.
- we2  output  1  memory port-2 write enable.
- btn_state  output  4  debounced button levels, 1 = pressed (for LEDs).
- irq  output  1  present only with MAILBOX_IRQ_EN.

Behaviour:
- All state is cleared asynchronously by reset.
- Reset values: dataIn2 = 0, we2 = 0, btn_state = 0, irq = 0, FSM = IDLE, pending = 0, seq = 0, ovr = 0.
- addr2 is tied to MAILBOX_ADDR at all times, including during reset.
- Input path, per button:
  - 2-flop synchroniser, then polarity normalisation per BTN_ACTIVE_LOW.
  - Debounce counter: counts while the synchronised level differs from btn_state, and clears to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, btn_state toggles and the counter clears.
  - Latency from a raw edge to a btn_state change: 2 + DEBOUNCE_CYCLES cycles.
- Press event: a btn_state 0->1 transition. Releases generate no event.
  - Each press sets pending[i].
  - If pending[i] is already 1 when the press arrives, ovr increments, saturating at 7.
- Mailbox word format:
  - [15] VALID = 1.
  - [14:12] ovr.
  - [11:4] seq, 8-bit, wraps 255->0.
  - [3:0] pending mask.
- FSM states and transitions:
  - IDLE: when io_en = 1 and pending != 0, go to WRITE. With io_en = 0, stay in IDLE; debouncing and accumulation continue.
  - WRITE (exactly 1 cycle):
    - we2 = 1, dataIn2 = {1, ovr, seq, pending}.
    - Clear pending and ovr; seq += 1.
    - A press event in this same cycle lands in the freshly cleared pending, with ovr starting from 0, so it is not lost.
    - Go to WAIT_ACK.
  - WAIT_ACK: we2 = 0; dataIn2 holds the last posted word. Go to IDLE when dataOut2[15] == 0, i.e. the CPU wrote a word with bit 15 clear to the mailbox via port 1. io_en dropping in this state has no effect; keep waiting.
- The minimum posting period is 3 cycles: WRITE, then at least 1 WAIT_ACK cycle, then IDLE.
- If the CPU writes the mailbox on port 1 in the same cycle as WRITE, the port-2 write wins (memory write ordering). Software must only clear the mailbox after observing VALID.
- Reset asserted during WRITE: we2 drops immediately (asynchronous). The memory contents written are undefined for that cycle, and the block restarts in IDLE.

Optional Feature:
- Macro MAILBOX_IRQ_EN.
- Defined: adds output port irq. irq = 1 exactly while the FSM is in WAIT_ACK (registered, rising the cycle after WRITE); irq resets to 0.
- Undefined: no irq port; behaviour is otherwise identical.

Test Plan (DEBOUNCE_CYCLES = 4, BTN_ACTIVE_LOW = 1, memory model of the Tron dual-port RAM):
1. Reset -> addr2 = 16'h8001, we2 = 0, dataIn2 = 0, btn_state = 0. Assert reset mid-WRITE -> we2 falls the same cycle, FSM returns to IDLE, seq = 0.
2. io_en = 1, btn_raw[0] low for 10 cycles -> btn_state[0] rises 6 cycles after the edge. One we2 pulse follows with dataIn2 = 16'h8001 (VALID, seq 0, mask 0001).
3. Glitch: btn_raw[1] low for 3 cycles, then high -> btn_state stays 0 and no write occurs.
4. While in WAIT_ACK, press btn 2, btn 3, then btn 2 again -> no write. CPU writes 16'h0000 to 16'h8001 -> next post is 16'h901C (ovr 1, seq 1, mask 1100).
5. io_en = 0, press btn 0 -> no write. Raise io_en -> write occurs within 2 cycles. Drive 256 acknowledged posts -> seq wraps to 0.
6. With MAILBOX_IRQ_EN defined -> irq high from the cycle after WRITE until the cycle after dataOut2[15] is seen 0. Without the macro -> compiles with no irq port.

Source files
------------

// File: rtl/input_mailbox.sv
// Debounced push-button mailbox: posts press events into one memory word via port 2.
// Optional MAILBOX_IRQ_EN adds an irq output that is high while a posted word awaits acknowledge.
module input_mailbox #(
    parameter logic [15:0] MAILBOX_ADDR    = 16'h8001,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn_raw,
    input  logic        io_en,
    input  logic [15:0] dataOut2,
    output logic [15:0] addr2,
    output logic [15:0] dataIn2,
    output logic        we2,
    output logic [3:0]  btn_state
`ifdef MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  IDLE_LVL = BTN_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_ACK} state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [2:0] ovr_sat_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[3] ? 3'd7 : sum[2:0];
    endfunction

    logic [3:0]  sync_p0, sync_p1;
    logic [3:0]  lvl;
    logic [15:0] db_cnt [4];
    logic [3:0]  toggle;
    logic [3:0]  press;
    state_t      state, state_nxt;
    logic [3:0]  pending;
    logic [2:0]  ovr;
    logic [7:0]  seq;
    logic [15:0] last_word;
    logic [15:0] post_word;
    logic        unused_rd_bits;

    assign addr2          = MAILBOX_ADDR;
    assign unused_rd_bits = ^dataOut2[14:0];
    assign lvl            = BTN_ACTIVE_LOW ? ~sync_p1 : sync_p1;
    assign press          = toggle & ~btn_state;
    assign post_word      = {1'b1, ovr, seq, pending};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            toggle[i] = (lvl[i] != btn_state[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Stage p0/p1: synchroniser, then per-button debounce counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= IDLE_LVL;
            sync_p1   <= IDLE_LVL;
            btn_state <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= 16'h0;
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            btn_state <= btn_state ^ toggle;
            for (int i = 0; i < 4; i++) begin
                if (lvl[i] == btn_state[i] || toggle[i])
                    db_cnt[i] <= 16'h0;
                else
                    db_cnt[i] <= db_cnt[i] + 16'h1;
            end
        end
    end

    // Event accumulation; a press during WRITE lands in the freshly cleared mask
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= 4'h0;
            ovr       <= 3'd0;
            seq       <= 8'd0;
            last_word <= 16'h0;
        end else if (state == WRITE) begin
            pending   <= press;
            ovr       <= 3'd0;
            seq       <= seq + 8'd1;
            last_word <= post_word;
        end else begin
            pending   <= pending | press;
            ovr       <= ovr_sat_add(ovr, popcount4(press & pending));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // we2 is decoded from state so an asynchronous reset drops it immediately
    always_comb begin
        state_nxt = state;
        we2       = 1'b0;
        dataIn2   = last_word;
        case (state)
            IDLE:     if (io_en && (pending != 4'h0)) state_nxt = WRITE;
            WRITE: begin
                we2       = 1'b1;
                dataIn2   = post_word;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: if (!dataOut2[15]) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

`ifdef MAILBOX_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= (state_nxt == WAIT_ACK);
    end
`endif

endmodule
